// File: rtl/ps2_device_if.sv
// rtl/ps2_device_if.sv - transmit/receive handshake bundle between a PS/2 device and its user
interface ps2_device_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_parity_err_o;
  logic       rx_frame_err_o;
  logic       tx_abort_o;
  logic       busy_o;

  modport slave (
    input  tx_data_i, tx_valid_i,
    output tx_ready_o, rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, tx_abort_o, busy_o
  );

  modport master (
    output tx_data_i, tx_valid_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, tx_abort_o, busy_o
  );
endinterface

// File: rtl/ps2_device.sv
// rtl/ps2_device.sv - PS/2 device endpoint generating the PS/2 clock; PS2_DEVICE_TX_FIFO_EN selects a 4-entry TX FIFO
module ps2_device #(
  parameter int HALF_PERIOD = 2000,
  parameter int CNT_BITS    = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ps2_device_if.slave bus,
  inout  wire         ps2_clk_io,
  inout  wire         ps2_data_io
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_TX_HI, ST_TX_LO, ST_RX_WAIT, ST_RX_LO, ST_RX_HI, ST_ACK_HI, ST_ACK_LO, ST_HOLDOFF
  } state_t;

  state_t              state_q;
  logic [CNT_BITS-1:0] timer_q;
  logic [3:0]          bit_idx_q;
  logic                clk_low_q, data_low_q;
  logic [1:0]          clk_sync_q, data_sync_q;
  logic [8:0]          rx_sr_q;
  logic [7:0]          rx_data_q;
  logic                rx_valid_q, rx_parity_err_q, rx_frame_err_q, tx_abort_q;
  logic                ready_q;

  logic                clk_s, data_s, tick, push, pop, tx_pending;
  logic [7:0]          tx_byte;
  logic [10:0]         tx_frame;

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign tick     = (timer_q == CNT_BITS'(HALF_PERIOD - 1));
  assign push     = bus.tx_valid_i & ready_q;
  assign pop      = (state_q == ST_TX_LO) & tick & (bit_idx_q == 4'd10);
  // Stop, odd parity, data LSB first, start; index = frame bit number
  assign tx_frame = {1'b1, ~^tx_byte, tx_byte, 1'b0};

  // Open-drain line drivers: pull low or release
  assign ps2_clk_io  = clk_low_q  ? 1'b0 : 1'bz;
  assign ps2_data_io = data_low_q ? 1'b0 : 1'bz;

  // Two-flop synchronisers; lines idle high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_io};
      data_sync_q <= {data_sync_q[0], ps2_data_io};
    end
  end

`ifdef PS2_DEVICE_TX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
  end

  // FIFO storage; the head leaves only once its stop bit has been clocked out
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.tx_data_i;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
      ready_q <= (count_d != 3'd4);
    end
  end

  assign tx_byte    = fifo_q[rd_ptr_q];
  assign tx_pending = (count_q != 3'd0);
`else
  logic [7:0] buf_q;
  logic       full_q;

  // Single holding register; kept across aborts, freed after the stop bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q   <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (push) begin
      buf_q   <= bus.tx_data_i;
      full_q  <= 1'b1;
      ready_q <= 1'b0;
    end else if (pop) begin
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end
  end

  assign tx_byte    = buf_q;
  assign tx_pending = full_q;
`endif

  // Line-protocol FSM with half-period timer; every transition restarts the timer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      bit_idx_q       <= '0;
      clk_low_q       <= 1'b0;
      data_low_q      <= 1'b0;
      rx_sr_q         <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      tx_abort_q      <= 1'b0;
    end else begin
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      tx_abort_q      <= 1'b0;
      timer_q         <= tick ? '0 : timer_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (clk_s && !data_s) begin
            state_q <= ST_RX_WAIT;
            timer_q <= '0;
          end else if (tx_pending && clk_s) begin
            state_q    <= ST_TX_HI;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            data_low_q <= ~tx_frame[0];
          end
        end
        ST_TX_HI: if (tick) begin
          if (!clk_s) begin
            state_q    <= ST_IDLE;
            data_low_q <= 1'b0;
            tx_abort_q <= 1'b1;
          end else begin
            state_q   <= ST_TX_LO;
            clk_low_q <= 1'b1;
          end
        end
        ST_TX_LO: if (tick) begin
          clk_low_q <= 1'b0;
          if (bit_idx_q == 4'd10) begin
            state_q    <= ST_HOLDOFF;
            data_low_q <= 1'b0;
          end else begin
            state_q    <= ST_TX_HI;
            bit_idx_q  <= bit_idx_q + 4'd1;
            data_low_q <= ~tx_frame[bit_idx_q + 4'd1];
          end
        end
        ST_RX_WAIT: if (tick) begin
          state_q   <= ST_RX_LO;
          bit_idx_q <= '0;
          clk_low_q <= 1'b1;
        end
        ST_RX_LO: if (tick) begin
          state_q   <= ST_RX_HI;
          clk_low_q <= 1'b0;
        end
        ST_RX_HI: if (tick) begin
          if (bit_idx_q == 4'd9) begin
            if (data_s) begin
              state_q    <= ST_ACK_HI;
              data_low_q <= 1'b1;
            end else begin
              state_q        <= ST_HOLDOFF;
              rx_frame_err_q <= 1'b1;
            end
          end else begin
            rx_sr_q[bit_idx_q] <= data_s;
            bit_idx_q          <= bit_idx_q + 4'd1;
            state_q            <= ST_RX_LO;
            clk_low_q          <= 1'b1;
          end
        end
        ST_ACK_HI: if (tick) begin
          state_q   <= ST_ACK_LO;
          clk_low_q <= 1'b1;
        end
        ST_ACK_LO: if (tick) begin
          state_q    <= ST_HOLDOFF;
          clk_low_q  <= 1'b0;
          data_low_q <= 1'b0;
          if (^rx_sr_q) begin
            rx_data_q  <= rx_sr_q[7:0];
            rx_valid_q <= 1'b1;
          end else begin
            rx_parity_err_q <= 1'b1;
          end
        end
        ST_HOLDOFF: if (tick) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_ready_o      = ready_q;
  assign bus.rx_data_o       = rx_data_q;
  assign bus.rx_valid_o      = rx_valid_q;
  assign bus.rx_parity_err_o = rx_parity_err_q;
  assign bus.rx_frame_err_o  = rx_frame_err_q;
  assign bus.tx_abort_o      = tx_abort_q;
  assign bus.busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_device.sv
// tb/tb_ps2_device.sv - directed self-checking bench for ps2_device with an open-drain host model
module tb_ps2_device;
  localparam int HP = 8;

  logic clk           = 1'b0;
  logic rst           = 1'b1;
  logic host_clk_low  = 1'b0;
  logic host_data_low = 1'b0;
  wire  ps2_clk;
  wire  ps2_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_abort = 0, n_falls = 0;
  int t_busy_rise = 0, t_ready_rise = 0;
  logic clk_prev = 1'b1, busy_prev = 1'b0, ready_prev = 1'b1;
  logic fall_data [64];

  ps2_device_if bus ();

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = host_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = host_data_low ? 1'b0 : 1'bz;

  ps2_device #(.HALF_PERIOD(HP), .CNT_BITS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .ps2_clk_io  (ps2_clk),
    .ps2_data_io (ps2_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, PS/2 clock falling-edge capture of the data line, edge timestamps
  always @(negedge clk) begin
    if (bus.rx_valid_o === 1'b1)      n_valid++;
    if (bus.rx_parity_err_o === 1'b1) n_perr++;
    if (bus.rx_frame_err_o === 1'b1)  n_ferr++;
    if (bus.tx_abort_o === 1'b1)      n_abort++;
    if (clk_prev === 1'b1 && ps2_clk === 1'b0) begin
      n_falls++;
      fall_data[n_falls[5:0]] = ps2_data;
    end
    if (bus.busy_o === 1'b1 && busy_prev === 1'b0)         t_busy_rise  = cyc;
    if (bus.tx_ready_o === 1'b1 && ready_prev === 1'b0)    t_ready_rise = cyc;
    clk_prev   = ps2_clk;
    busy_prev  = bus.busy_o;
    ready_prev = bus.tx_ready_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_falls(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      step();
      if (n_falls >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      step();
      if (bus.busy_o === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic frame_bits(input int first, output logic [10:0] bits);
    int idx;
    for (int i = 0; i < 11; i++) begin
      idx     = first + i;
      bits[i] = fall_data[idx[5:0]];
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    step();
    bus.tx_valid_i = 1'b0;
  endtask

  // Host-to-device frame: request by pulling data low, new bit after each clock fall
  task automatic host_send(input logic [7:0] d, input logic par, input logic stop,
                           input bit with_tx, input logic [7:0] txd,
                           output logic ack, output bit ok);
    logic [9:0] bits;
    int         f0, e0, idx;
    bit         w;
    bits = {stop, par, d};
    f0   = n_falls;
    ok   = 1'b1;
    ack  = 1'b1;
    host_data_low = 1'b1;
    if (with_tx) begin
      step();
      step();
      push_byte(txd);
    end
    for (int i = 0; i < 10; i++) begin
      wait_falls(f0 + i + 1, w);
      ok = ok & w;
      host_data_low = ~bits[i];
    end
    if (stop) begin
      wait_falls(f0 + 11, w);
      ok  = ok & w;
      idx = f0 + 11;
      ack = fall_data[idx[5:0]];
    end else begin
      e0 = n_ferr;
      w  = 1'b0;
      for (int i = 0; i < 600 && !w; i++) begin
        step();
        if (n_ferr != e0) w = 1'b1;
      end
      ok = ok & w;
      host_data_low = 1'b0;
    end
  endtask

  initial begin
    logic        ack;
    bit          ok, ok2;
    logic [10:0] bits;
    int          f0, v0, p0, e0, a0;

    bus.tx_data_i  = 8'h00;
    bus.tx_valid_i = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_tx_ready",  32'(bus.tx_ready_o), 1);
    check("rst_rx_data",   32'(bus.rx_data_o), 0);
    check("rst_busy",      32'(bus.busy_o), 0);
    check("rst_clk_line",  32'(ps2_clk), 1);
    check("rst_data_line", 32'(ps2_data), 1);
    check("rst_pulses",    32'({bus.rx_valid_o, bus.rx_parity_err_o, bus.rx_frame_err_o, bus.tx_abort_o}), 0);
    rst = 1'b0;
    repeat (4) step();

    // Transmit 0x5A
    f0 = n_falls;
    push_byte(8'h5A);
`ifndef PS2_DEVICE_TX_FIFO_EN
    check("tx_ready_drops", 32'(bus.tx_ready_o), 0);
`endif
    wait_falls(f0 + 11, ok);
    wait_idle(ok2);
    check("tx_5a_done", 32'(ok & ok2), 1);
    frame_bits(f0 + 1, bits);
    check("tx_5a_frame", 32'(bits), 32'b11_01011010_0);
`ifndef PS2_DEVICE_TX_FIFO_EN
    check("tx_5a_cycles", 32'(t_ready_rise - t_busy_rise), 176);
`endif
    check("tx_ready_back", 32'(bus.tx_ready_o), 1);

    // Receive 0xED with correct odd parity
    v0 = n_valid; p0 = n_perr; f0 = n_falls;
    host_send(8'hED, 1'b1, 1'b1, 1'b0, 8'h00, ack, ok);
    wait_idle(ok2);
    check("rx_ed_done",   32'(ok & ok2), 1);
    check("rx_ed_ack",    32'(ack), 0);
    check("rx_ed_data",   32'(bus.rx_data_o), 32'hED);
    check("rx_ed_valid",  32'(n_valid - v0), 1);
    check("rx_ed_perr",   32'(n_perr - p0), 0);
    check("rx_ed_pulses", 32'(n_falls - f0), 11);

    // Receive 0x12 with wrong parity
    v0 = n_valid; p0 = n_perr;
    host_send(8'h12, 1'b0, 1'b1, 1'b0, 8'h00, ack, ok);
    wait_idle(ok2);
    check("rx_12_done",  32'(ok & ok2), 1);
    check("rx_12_ack",   32'(ack), 0);
    check("rx_12_perr",  32'(n_perr - p0), 1);
    check("rx_12_valid", 32'(n_valid - v0), 0);
    check("rx_12_held",  32'(bus.rx_data_o), 32'hED);

    // Receive with stop bit 0
    v0 = n_valid; e0 = n_ferr; f0 = n_falls;
    host_send(8'h55, 1'b1, 1'b0, 1'b0, 8'h00, ack, ok);
    wait_idle(ok2);
    check("rx_fe_done",   32'(ok & ok2), 1);
    check("rx_fe_ferr",   32'(n_ferr - e0), 1);
    check("rx_fe_valid",  32'(n_valid - v0), 0);
    check("rx_fe_pulses", 32'(n_falls - f0), 10);
    check("rx_fe_data",   32'(ps2_data), 1);
    check("rx_fe_held",   32'(bus.rx_data_o), 32'hED);

    // Host inhibit during data bit 3 of 0xAA, then resend
    a0 = n_abort; f0 = n_falls;
    push_byte(8'hAA);
    wait_falls(f0 + 4, ok);
    for (int i = 0; i < 600 && ps2_clk !== 1'b1; i++) step();
    step();
    host_clk_low = 1'b1;
    for (int i = 0; i < 600 && n_abort == a0; i++) step();
    check("abort_pulse",    32'(n_abort - a0), 1);
    check("abort_data_rel", 32'(ps2_data), 1);
    check("abort_busy",     32'(bus.busy_o), 0);
`ifndef PS2_DEVICE_TX_FIFO_EN
    check("abort_buf_kept", 32'(bus.tx_ready_o), 0);
`endif
    repeat (5 * HP) step();
    check("inhibit_blocks", 32'(bus.busy_o), 0);
    host_clk_low = 1'b0;
    f0 = n_falls;
    wait_falls(f0 + 11, ok);
    wait_idle(ok2);
    check("resend_done",  32'(ok & ok2), 1);
    frame_bits(f0 + 1, bits);
    check("resend_frame", 32'(bits), 32'b11_10101010_0);

    // tx_valid_i together with a host request: receive first, then send
    v0 = n_valid; f0 = n_falls;
    host_send(8'h81, 1'b1, 1'b1, 1'b1, 8'hC3, ack, ok);
    check("sim_rx_done", 32'(ok), 1);
    check("sim_rx_ack",  32'(ack), 0);
`ifndef PS2_DEVICE_TX_FIFO_EN
    check("sim_tx_waits", 32'(bus.tx_ready_o), 0);
`endif
    wait_falls(f0 + 22, ok);
    wait_idle(ok2);
    check("sim_tx_done",  32'(ok & ok2), 1);
    check("sim_rx_data",  32'(bus.rx_data_o), 32'h81);
    check("sim_rx_valid", 32'(n_valid - v0), 1);
    frame_bits(f0 + 12, bits);
    check("sim_tx_frame", 32'(bits), 32'b11_11000011_0);

    // Reset in the middle of a transmit
    f0 = n_falls;
    push_byte(8'h77);
    wait_falls(f0 + 3, ok);
    rst = 1'b1;
    #1;
    check("mid_rst_clk",   32'(ps2_clk), 1);
    check("mid_rst_data",  32'(ps2_data), 1);
    check("mid_rst_busy",  32'(bus.busy_o), 0);
    check("mid_rst_ready", 32'(bus.tx_ready_o), 1);
    step();
    rst = 1'b0;
    f0 = n_falls;
    repeat (100) step();
    check("mid_rst_dropped", 32'(n_falls - f0), 0);

`ifdef PS2_DEVICE_TX_FIFO_EN
    begin
      logic [10:0] exp_fifo [4];
      exp_fifo[0] = 11'b1_0_00000001_0;
      exp_fifo[1] = 11'b1_0_00000010_0;
      exp_fifo[2] = 11'b1_1_00000011_0;
      exp_fifo[3] = 11'b1_0_00000100_0;
      f0 = n_falls;
      bus.tx_valid_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        bus.tx_data_i = 8'(i);
        step();
      end
      bus.tx_valid_i = 1'b0;
      check("fifo_full", 32'(bus.tx_ready_o), 0);
      wait_falls(f0 + 44, ok);
      wait_idle(ok2);
      check("fifo_done", 32'(ok & ok2), 1);
      for (int i = 0; i < 4; i++) begin
        frame_bits(f0 + 1 + 11 * i, bits);
        check("fifo_frame", 32'(bits), 32'(exp_fifo[i]));
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
